// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA store enqueues a byte into a small
// FIFO, STATUS reports count/overflow/full/empty/busy; FSM serialises LSB first.
module mmio_uart_tx #(
  parameter int             N            = 32,
  parameter logic [N-1:0]   BASE         = N'(32'h0000_FF00),
  parameter int             CLKS_PER_BIT = 16,
  parameter int             DEPTH        = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         memwrite,
  input  logic [N-1:0] dataadr,
  input  logic [N-1:0] writedata,
  output logic [N-1:0] rdata,
  output logic         tx,
  output logic         busy
);

  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [N-1:0]      STAT_ADR  = BASE + N'(4);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  typedef struct packed {
    logic       tx_wr;
    logic       ovf_clr;
    logic       stat_rd;
    logic [7:0] wbyte;
  } bus_req_t;

  bus_req_t req;

  state_e state_q, state_d;

  logic [DEPTH-1:0][7:0] mem_q, mem_d;
  logic [PTR_W-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ovf_q, ovf_d;

  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [2:0]            bit_q, bit_d;
  logic [7:0]            shreg_q, shreg_d;

  logic push, pop, ovf_set, baud_end;
  logic full, empty;
  logic [2:0] cnt3;

  logic unused_wdata_hi;
  assign unused_wdata_hi = ^writedata[N-1:8];

  // Full-width address compare, so no aliasing on upper address bits.
  always_comb begin
    req         = '0;
    req.tx_wr   = memwrite && (dataadr == BASE);
    req.ovf_clr = memwrite && (dataadr == STAT_ADR) && writedata[0];
    req.stat_rd = (dataadr == STAT_ADR);
    req.wbyte   = writedata[7:0];
  end

  assign full     = (count_q == CNT_FULL);
  assign empty    = (count_q == '0);
  assign pop      = (state_q == S_IDLE) && !empty;
  // A full FIFO still accepts when the head leaves on the same edge.
  assign push     = req.tx_wr && (!full || pop);
  assign ovf_set  = req.tx_wr && !push;
  assign baud_end = (baud_q == BAUD_LAST);

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (push) begin
      mem_d[wptr_q] = req.wbyte;
      wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + PTR_W'(1);
    end
    if (pop)
      rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // A rejected push on the same edge as a clear keeps the flag set.
    if (ovf_set)          ovf_d = 1'b1;
    else if (req.ovf_clr) ovf_d = 1'b0;
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (pop)                          state_d = S_START;
      S_START: if (baud_end)                     state_d = S_DATA;
      S_DATA:  if (baud_end && (bit_q == 3'd7))  state_d = S_STOP;
      S_STOP:  if (baud_end)                     state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    tx   = 1'b1;
    busy = (state_q != S_IDLE);
    unique case (state_q)
      S_START: tx = 1'b0;
      S_DATA:  tx = shreg_q[0];
      default: tx = 1'b1;
    endcase
  end

  // Baud counter, bit index and shifter; bit index wraps 7->0 on entry to STOP.
  always_comb begin
    baud_d  = baud_q + BAUD_W'(1);
    bit_d   = bit_q;
    shreg_d = shreg_q;
    unique case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (pop) shreg_d = mem_q[rptr_q];
      end
      S_START: if (baud_end) baud_d = '0;
      S_DATA: if (baud_end) begin
        baud_d  = '0;
        bit_d   = bit_q + 3'd1;
        shreg_d = {1'b0, shreg_q[7:1]};
      end
      S_STOP: if (baud_end) baud_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
    end
  end

  assign cnt3 = 3'(count_q);

  always_comb begin
    rdata = '0;
    if (req.stat_rd) rdata[6:0] = {cnt3, ovf_q, full, empty, busy};
  end

endmodule
